// File: rtl/cicero_host_sequencer.sv
// cicero_host_sequencer: host-side request sequencer for the AXI_top register file.
// Takes one WRITE / READ / RUN request at a time, walks the command register through
// the required sequence and returns exactly one response per request.
// Every output is a flop; the FSM computes next-values and one register stage commits them.
module cicero_host_sequencer #(
  parameter int REG_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int START_HOLD     = 2,
  // Register-map encodings shared with AXI_top
  parameter logic [REG_WIDTH-1:0] CMD_NOP                = REG_WIDTH'(0),
  parameter logic [REG_WIDTH-1:0] CMD_WRITE              = REG_WIDTH'(1),
  parameter logic [REG_WIDTH-1:0] CMD_READ               = REG_WIDTH'(2),
  parameter logic [REG_WIDTH-1:0] CMD_START              = REG_WIDTH'(3),
  parameter logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = REG_WIDTH'(4),
  parameter logic [REG_WIDTH-1:0] STATUS_RUNNING         = REG_WIDTH'(1),
  parameter logic [REG_WIDTH-1:0] STATUS_ACCEPTED        = REG_WIDTH'(2),
  parameter logic [REG_WIDTH-1:0] STATUS_REJECTED        = REG_WIDTH'(3)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [REG_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0] req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_code,
  output logic [REG_WIDTH-1:0] rsp_data,
  output logic [REG_WIDTH-1:0] address_register,
  output logic [REG_WIDTH-1:0] data_in_register,
  output logic [REG_WIDTH-1:0] start_cc_pointer_register,
  output logic [REG_WIDTH-1:0] end_cc_pointer_register,
  output logic [REG_WIDTH-1:0] cmd_register,
  input  logic [REG_WIDTH-1:0] status_register,
  input  logic [REG_WIDTH-1:0] data_o_register
);

  // Counter widths: the timeout counter only has to reach TIMEOUT_CYCLES-1,
  // the start-hold counter only START_HOLD-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);

  localparam logic [1:0] RC_OK       = 2'd0;
  localparam logic [1:0] RC_REJECTED = 2'd1;
  localparam logic [1:0] RC_TIMEOUT  = 2'd2;
  localparam logic [1:0] RC_ERROR    = 2'd3;

  typedef enum logic [3:0] {
    IDLE, WR_SETUP, WR_CMD, RD_SETUP, RD_CMD, RD_WAIT, RD_CAP,
    ST_SETUP, ST_CMD, ST_CHECK, RUN_WAIT, CC_CMD, CC_CAP, RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [1:0]             run_code_q, run_code_d;   // RUN verdict parked while the CC read runs
  logic                   req_ready_d, rsp_valid_d;
  logic [1:0]             rsp_code_d;
  logic [REG_WIDTH-1:0]   rsp_data_d, addr_d, din_d, sp_d, ep_d, cmd_d;

  // Next-state and next-output decode; each state's register values are loaded on entry.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    hold_d      = hold_q;
    run_code_d  = run_code_q;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_code_d  = rsp_code;
    rsp_data_d  = rsp_data;
    addr_d      = address_register;
    din_d       = data_in_register;
    sp_d        = start_cc_pointer_register;
    ep_d        = end_cc_pointer_register;
    cmd_d       = cmd_register;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          cmd_d       = CMD_NOP;
          case (req_op)
            2'd0: begin
              state_d = WR_SETUP;
              addr_d  = req_addr;
              din_d   = req_data;
            end
            2'd1: begin
              state_d = RD_SETUP;
              addr_d  = req_addr;
            end
            2'd2: begin
              state_d = ST_SETUP;
              sp_d    = req_addr;
              ep_d    = req_data;
            end
            default: begin
              // Reserved opcode: no register traffic, straight to an ERROR response.
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_code_d  = RC_ERROR;
              rsp_data_d  = '0;
            end
          endcase
        end
      end
      WR_SETUP: begin
        state_d = WR_CMD;
        cmd_d   = CMD_WRITE;
      end
      WR_CMD: begin
        state_d     = RESP;
        cmd_d       = CMD_NOP;
        rsp_valid_d = 1'b1;
        rsp_code_d  = RC_OK;
        rsp_data_d  = '0;
      end
      RD_SETUP: begin
        state_d = RD_CMD;
        cmd_d   = CMD_READ;
      end
      RD_CMD: begin
        state_d = RD_WAIT;
        cmd_d   = CMD_NOP;
      end
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_code_d  = RC_OK;
        rsp_data_d  = data_o_register;
      end
      ST_SETUP: begin
        state_d = ST_CMD;
        cmd_d   = CMD_START;
        hold_d  = '0;
      end
      ST_CMD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_CHECK;
          cmd_d   = CMD_NOP;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_CHECK: begin
        // The engine must report RUNNING once START has been held; anything else is a failed launch.
        if (status_register != STATUS_RUNNING) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_code_d  = RC_ERROR;
          rsp_data_d  = '0;
        end else begin
          state_d  = RUN_WAIT;
          to_cnt_d = '0;
        end
      end
      RUN_WAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // A status change is checked before the timeout so it wins a same-cycle tie.
        if (status_register != STATUS_RUNNING) begin
          state_d = CC_CMD;
          cmd_d   = CMD_READ_ELAPSED_CLOCK;
          if (status_register == STATUS_ACCEPTED)      run_code_d = RC_OK;
          else if (status_register == STATUS_REJECTED) run_code_d = RC_REJECTED;
          else                                         run_code_d = RC_ERROR;
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_code_d  = RC_TIMEOUT;
          rsp_data_d  = '0;
        end
      end
      CC_CMD: begin
        state_d = CC_CAP;
        cmd_d   = CMD_NOP;
      end
      CC_CAP: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_code_d  = run_code_q;
        rsp_data_d  = data_o_register;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_d       = CMD_NOP;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any sequence without a response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q                   <= IDLE;
      to_cnt_q                  <= '0;
      hold_q                    <= '0;
      run_code_q                <= RC_OK;
      req_ready                 <= 1'b1;
      rsp_valid                 <= 1'b0;
      rsp_code                  <= RC_OK;
      rsp_data                  <= '0;
      address_register          <= '0;
      data_in_register          <= '0;
      start_cc_pointer_register <= '0;
      end_cc_pointer_register   <= '0;
      cmd_register              <= CMD_NOP;
    end else begin
      state_q                   <= state_d;
      to_cnt_q                  <= to_cnt_d;
      hold_q                    <= hold_d;
      run_code_q                <= run_code_d;
      req_ready                 <= req_ready_d;
      rsp_valid                 <= rsp_valid_d;
      rsp_code                  <= rsp_code_d;
      rsp_data                  <= rsp_data_d;
      address_register          <= addr_d;
      data_in_register          <= din_d;
      start_cc_pointer_register <= sp_d;
      end_cc_pointer_register   <= ep_d;
      cmd_register              <= cmd_d;
    end
  end

endmodule
